// File: rtl/serial_full_subtractor_pkg.sv
// serial_sub_pkg: shared state encoding for the bit-serial subtractor.
package serial_sub_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_full_subtractor_cell.sv
// full_subtractor_cell: one-bit combinational full subtractor (d = a - b - bin).
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor: LSB-first bit-serial a - b - bin over WIDTH cycles with start/done handshake.
// Optional signed overflow flag on port ovf when SERIAL_SUB_OVF_EN is defined.
module serial_full_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             br, d, bo, accept, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif
    // Ready in IDLE and DONE, so a start seen in DONE chains straight into the next op.
    assign accept = start && (state != SHIFT);
    assign last   = cnt == CW'(WIDTH - 1);
    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d),
        .bout (bo)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            br    <= 1'b0;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= SHIFT;
                busy  <= 1'b1;
                a_sr  <= a;
                b_sr  <= b;
                br    <= bin;
                cnt   <= '0;
                diff  <= '0;
                bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                ovf   <= 1'b0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
`endif
            end else if (state == SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                diff <= {d, diff[WIDTH-1:1]};
                br   <= bo;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    bout  <= bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf   <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb_serial_full_subtractor: random + directed scoreboard bench for serial_full_subtractor.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_full_subtractor;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic         clk = 0, rst_n = 0, start = 0, bin = 0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif
    exp_t q[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0;
    logic prev_done = 0;

    serial_full_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        exp_t e;
        int   r;
        e.diff = W'(int'(ia) - int'(ib) - int'(ibin));
        e.bout = int'(ia) < int'(ib) + int'(ibin);
        r      = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
        e.ovf  = (r < -(2 ** (W - 1))) || (r > 2 ** (W - 1) - 1);
        e.acc  = 0;
        return e;
    endfunction

    // Call from a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        exp_t e;
        int   t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 1, 0);
        start = 1; a = ia; b = ib; bin = ibin;
        @(posedge clk);
        #1;
        e = model(ia, ib, ibin);
        e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("done_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            chk("done_width", prev_done, 0);
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("diff", diff, e.diff);
                chk("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", ovf, e.ovf);
`endif
                chk("latency", cyc - e.acc, W);
            end
        end
        prev_done = done;
    end

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        issue(8'h05, 8'h03, 0);
        wait_done();
        @(negedge clk);
        issue(8'h03, 8'h05, 0);
        issue(8'h00, 8'hFF, 1);
        issue(8'h80, 8'h01, 0);
        issue(8'h80, 8'h00, 1);
        issue(8'h7F, 8'hFF, 1);
        // start mid-operation must be ignored
        issue(8'h5A, 8'h21, 1);
        repeat (2) @(negedge clk);
        start = 1; a = 8'hFF; b = 8'h00; bin = 0;
        @(negedge clk);
        start = 0;
        // chain directly out of DONE
        wait_done();
        issue(8'h10, 8'h20, 0);
        wait_done();
        issue(8'hC3, 8'h3C, 1);
        // abort at bit 4
        wait_done();
        @(negedge clk);
        issue(8'hAA, 8'h55, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", ovf, 0);
`endif
        void'(q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        issue(8'h37, 8'h12, 1);
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                wait_done();
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
        end
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
